riscv_fetch_unit: RTL

//  Instruction fetch stage directly upstream of riscv_top. Owns the PC and issues

---
 rtl/riscv_fetch_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO, redirect flush
module riscv_fetch_unit #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_data,
    output logic [WIDTH-1:0] instr_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] rsp_pc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop_cnt;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

    logic             req_fire;
    logic             push;
    logic             pop;
    logic             drop;
    logic [CW:0]      credit_used;
    logic [WIDTH-1:0] redirect_aligned;

    // Every issued request reserves a FIFO slot, so responses can never overflow it.
    assign credit_used      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid   = !rst && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr    = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};

    assign drop        = imem_rsp_valid && (drop_cnt != '0);
    assign push        = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr_data  = fifo_data[head];
    assign instr_pc    = fifo_pc[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Whatever is still in flight belongs to the old path and must be discarded.
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + WIDTH'(4);
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    fifo_data[tail] <= imem_rsp_data;
                    fifo_pc[tail]   <= rsp_pc;
                    tail            <= tail + AW'(1);
                    rsp_pc          <= rsp_pc + WIDTH'(4);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule
